// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding, widths
// and the operand magnitude helper.
package div_pkg;

    localparam int DIV_W  = 32;
    localparam int ITER_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Two's-complement absolute value, applied only when the operand is signed.
    function automatic logic [DIV_W-1:0] mag(input logic [DIV_W-1:0] v, input logic sgn);
        return (sgn && v[DIV_W-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring iteration: shift {rem, quot} left and trial-subtract the divisor.
// Zero latency, no flow control; the caller registers the outputs.
module div_step
    import div_pkg::*;
(
    input  logic [DIV_W-1:0] i_rem,
    input  logic [DIV_W-1:0] i_quot,
    input  logic [DIV_W-1:0] i_dsr,
    output logic [DIV_W-1:0] o_rem,
    output logic [DIV_W-1:0] o_quot
);

    logic [DIV_W:0] w_shift;
    logic [DIV_W:0] w_diff;

    // The partial remainder is always below the divisor, so 33 bits hold the shifted value.
    assign w_shift = {i_rem, i_quot[DIV_W-1]};
    assign w_diff  = w_shift - {1'b0, i_dsr};

    always_comb begin
        o_rem  = w_shift[DIV_W-1:0];
        o_quot = {i_quot[DIV_W-2:0], 1'b0};
        if (!w_diff[DIV_W]) begin
            o_rem  = w_diff[DIV_W-1:0];
            o_quot = {i_quot[DIV_W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// 32-bit signed/unsigned restoring divider; done_o 34 cycles after start (1 cycle on divide-by-zero).
// No backpressure: start_i is ignored unless idle, results are held until the next accepted start.
module seq_divider
    import div_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [DIV_W-1:0] dividend_i,
    input  logic [DIV_W-1:0] divisor_i,
    output logic [DIV_W-1:0] quot_o,
    output logic [DIV_W-1:0] rem_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             dbz_o
);

    state_t              r_state;
    state_t              w_next;
    logic [ITER_W-1:0]   r_cnt;
    logic [DIV_W-1:0]    r_rem;
    logic [DIV_W-1:0]    r_quot;
    logic [DIV_W-1:0]    r_dsr;
    logic                r_qneg;
    logic                r_rneg;
    logic [DIV_W-1:0]    w_step_rem;
    logic [DIV_W-1:0]    w_step_quot;

    div_step u_step (
        .i_rem  (r_rem),
        .i_quot (r_quot),
        .i_dsr  (r_dsr),
        .o_rem  (w_step_rem),
        .o_quot (w_step_quot)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (start_i) w_next = (divisor_i == '0) ? DONE : CALC;
            CALC: if (r_cnt == ITER_W'(DIV_W - 1)) w_next = FIX;
            FIX:  w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quot <= '0;
            r_dsr  <= '0;
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
            quot_o <= '0;
            rem_o  <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            dbz_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i && divisor_i == '0) begin
                        quot_o <= '1;
                        rem_o  <= dividend_i;
                        dbz_o  <= 1'b1;
                        done_o <= 1'b1;
                    end else if (start_i) begin
                        // The quotient register starts out holding the dividend; its bits shift out MSB first.
                        r_quot <= mag(dividend_i, signed_i);
                        r_dsr  <= mag(divisor_i, signed_i);
                        r_rem  <= '0;
                        r_cnt  <= '0;
                        r_qneg <= signed_i & (dividend_i[DIV_W-1] ^ divisor_i[DIV_W-1]);
                        r_rneg <= signed_i & dividend_i[DIV_W-1];
                        dbz_o  <= 1'b0;
                        busy_o <= 1'b1;
                    end
                end
                CALC: begin
                    r_rem  <= w_step_rem;
                    r_quot <= w_step_quot;
                    r_cnt  <= r_cnt + ITER_W'(1);
                end
                FIX: begin
                    quot_o <= r_qneg ? (~r_quot + 1'b1) : r_quot;
                    rem_o  <= r_rneg ? (~r_rem + 1'b1) : r_rem;
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
